lab0_uart_rx: RTL
=================

# lab0_uart_rx

Receive half of the lab 0 UART. Consumes the serial line driven by the transmitter's `tx_o` (in loopback, or from the Zedboard's USB-UART), recovers 8N1 frames, and presents each byte in a holding register with a ready/acknowledge handshake toward the LED/register logic. Includes the input synchroniser, start-bit glitch rejection, framing-error detection and overrun flagging.

## Interface

- `DIVISOR`, 868: clock cycles per bit (100 MHz / 115200). Must be even, ≥ 8.
- `clk_i`  in  1  system clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low (0 = reset).
- `rx_i`  in  1  serial line, idle high, asynchronous to `clk_i`.
- `ack_i`  in  1  consumer has taken `data_o`; sampled on the clock edge.
- `data_o`  out  8  last good received byte.
- `rdy_o`  out  1  `data_o` holds an unacknowledged byte.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  sticky: a byte completed while `rdy_o`=1 and no `ack_i`.
- `busy_o`  out  1  state ≠ IDLE.

## Operation

- Synchroniser: two flops `rx_s1` → `rx_s`, both reset to 1. All decisions use `rx_s` only.
- Counters: `cnt` ($clog2(DIVISOR) bits), `bitidx` (3 bits), `shreg` (8 bits). H = DIVISOR/2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `rx_s`==0 → START, `cnt`←0.
  - START: `cnt`++ each cycle. When `cnt`==H−1: if `rx_s`==0 → DATA, `cnt`←0, `bitidx`←0; else → IDLE (glitch, no output).
  - DATA: `cnt`++. When `cnt`==DIVISOR−1: `shreg`←{`rx_s`, `shreg`[7:1]} (LSB first), `cnt`←0, `bitidx`++. On 8th sample (`bitidx`==7) → STOP.
  - STOP: `cnt`++. When `cnt`==DIVISOR−1: if `rx_s`==1 → `data_o`←`shreg`, `rdy_o`←1, else `frame_err_o` pulses, `data_o`/`rdy_o` unchanged. Either way → IDLE.
- IDLE re-arms immediately after the stop sample; back-to-back frames with a single stop bit are received without loss.
- Handshake: `ack_i`=1 clears `rdy_o` and `overrun_o` next edge. `ack_i` while `rdy_o`=0 has no effect.
- Simultaneous good-byte completion and `ack_i`: new byte loaded, `rdy_o` stays 1, `overrun_o` not set (ack applies to old byte).
- Good-byte completion with `rdy_o`=1 and `ack_i`=0: `data_o` overwritten with new byte, `overrun_o`←1, `rdy_o` stays 1.
- Framing error never sets `overrun_o` and never touches `data_o`.

## Timing

- Reset (async, `rst_i`=0): state IDLE, `cnt`/`bitidx`/`shreg` = 0, `data_o`=8'h00, `rdy_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0, sync flops = 1. Reset mid-frame abandons the frame; no pulse on release.
- Latency: let E0 be the first edge at which `rx_i`=0 is sampled into `rx_s1`. START entered at E2; data bit k sampled at E(2+H+(k+1)·DIVISOR), k=0..7; stop sampled at E(2+H+9·DIVISOR). `rdy_o` / `frame_err_o` visible after that edge. DIVISOR=868 → 8248 cycles.
- Sample point = bit centre ± 1 cycle; tolerates ±4 % baud mismatch.
- `frame_err_o` high exactly one cycle. `busy_o` falls the same edge `rdy_o` rises.
- A low pulse on `rx_i` shorter than H cycles (as seen on `rx_s`) returns to IDLE without output.

## Test plan

Benches run DIVISOR=16 (H=8, frame latency 154 cycles) with 10 ns clock and loop `rx_i` from a bit-accurate driver or the lab 0 transmitter.

- Single frame 0x41, `ack_i`=0 → `rdy_o` rises 154 cycles after E0, `data_o`=8'h41, `overrun_o`=0, `frame_err_o` never pulses.
- Back-to-back 0x55 then 0xA3, `ack_i` pulsed 1 cycle after each `rdy_o` → `data_o` 8'h55 then 8'hA3, `rdy_o` deasserts after each ack, no overrun.
- Two frames 0x12, 0x34 with no ack → `data_o`=8'h34, `rdy_o`=1, `overrun_o`=1; then `ack_i` → both 0 next cycle. Repeat with `ack_i` on the exact completion edge of 0x34 → `overrun_o`=0, `rdy_o`=1.
- Frame 0xF0 with stop bit driven low → one-cycle `frame_err_o`, `data_o` keeps previous value, `rdy_o` unchanged; following good frame 0x0F received correctly.
- 5-cycle low glitch on idle line → `busy_o` high ≤ 9 cycles, no `rdy_o`/`frame_err_o`; `rst_i` low during bit 4 of a frame → all outputs at reset values immediately, next full frame 0x7E received correctly.

Source files
------------

// File: rtl/lab0_uart_rx.sv
// 8N1 UART receiver: synchroniser, start-glitch rejection, framing and overrun flags, ready/ack holding register.
// Latency: rdy_o/frame_err_o update 2 + DIVISOR/2 + 9*DIVISOR cycles after rx_i first samples low.
// Backpressure: none on the line; an unacknowledged byte is overwritten by the next good byte and overrun_o is set.
module lab0_uart_rx #(
    parameter int DIVISOR = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       rdy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            rx_s1_q, rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitidx_q, bitidx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic            sample_bit;
    logic            stop_good;
    logic            stop_bad;

    // Two-flop synchroniser; idle-high reset so reset release never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_s1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s_q  <= rx_s1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start bit re-checked at its centre, eight data samples, one stop sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s_q) state_d = START;
            START: if (cnt_q == CNT_HALF) state_d = rx_s_q ? IDLE : DATA;
            DATA:  if (cnt_q == CNT_LAST && bitidx_q == 3'd7) state_d = STOP;
            STOP:  if (cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the per-sample strobes that drive the datapath.
    always_comb begin
        busy_o     = (state_q != IDLE);
        sample_bit = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state_q)
            DATA: sample_bit = (cnt_q == CNT_LAST);
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    stop_good = rx_s_q;
                    stop_bad  = !rx_s_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath next state: bit timer, shift register and holding-register handshake.
    always_comb begin
        // Timer restarts on every state change and at each full-bit sample point.
        if (state_q == IDLE || state_d != state_q || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        bitidx_d = bitidx_q;
        if (state_q == START) begin
            bitidx_d = 3'd0;
        end else if (sample_bit) begin
            bitidx_d = bitidx_q + 3'd1;
        end

        shreg_d = shreg_q;
        if (sample_bit) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
        end

        data_d = stop_good ? shreg_q : data_q;

        // A new byte wins over a same-edge ack, which is taken to retire the previous byte.
        if (stop_good) begin
            rdy_d = 1'b1;
        end else if (ack_i) begin
            rdy_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end

        if (stop_good && rdy_q && !ack_i) begin
            ovr_d = 1'b1;
        end else if (ack_i && rdy_q) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        ferr_d = stop_bad;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            bitidx_q <= 3'd0;
            shreg_q  <= 8'h00;
            data_q   <= 8'h00;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign rdy_o       = rdy_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule
